// File: rtl/mixcol_seq.sv
// rtl/mixcol_seq.sv - byte-serial sequencer around the MixColumns byte unit
//
// Takes a 128-bit AES state, issues it one byte per cycle to an external
// MixColumns byte unit and rebuilds the mixed columns from the returned words.
// The mixed state is then offered downstream with a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input state handshake (accepted only in IDLE)
//   in_state, in_last   state (byte k = in_state[127-8k -: 8]), final-round flag
//   mc_byte             byte presented to the unit (0 when not issuing)
//   mc_last_round       last_round flag presented to the unit
//   mc_word             unit result {2a,3a,a,a} or {24'b0,a}, same cycle
//   out_valid/out_ready output state handshake
//   out_state           mixed state, same byte ordering as in_state
//   busy                high while the state is being fed
//
// Build option: MIXCOL_SEQ_PIPE_EN registers mc_word before accumulation,
// adding one drain cycle to FEED (latency 17 instead of 16).

module mixcol_seq #(
  parameter int NCOL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*NCOL-1:0]    in_state,
  input  logic                  in_last,
  output logic [7:0]            mc_byte,
  output logic                  mc_last_round,
  input  logic [31:0]           mc_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NCOL-1:0]    out_state,
  output logic                  busy
);

  localparam int CW   = $clog2(4*NCOL);
  localparam int COLW = CW - 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(4*NCOL-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FEED = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           st;
  logic [32*NCOL-1:0]   state_q;
  logic                 last_q;
  logic [CW-1:0]        cnt;
  logic [31:0]          acc;
  logic [32*NCOL-1:0]   out_q;
  logic [32*NCOL-1:0]   state_sh;
  logic                 issue;

  // Accumulator operands: either straight from the unit or from the pipe stage.
  logic                 a_en;
  logic [31:0]          a_word;
  logic [1:0]           a_r;
  logic [COLW-1:0]      a_col;
  logic                 a_last;
  logic [31:0]          contrib;
  logic [31:0]          col_res;

  // Normal round: byte-reverse {2a,3a,a,a} to {a,a,3a,2a}, then rotate so the
  // 2a coefficient lands on row r. Last round: the raw byte goes to row r only.
  function automatic logic [31:0] contrib_f(input logic [31:0] w,
                                            input logic [1:0]  r,
                                            input logic        last);
    logic [31:0] rev;
    rev = {w[7:0], w[15:8], w[23:16], w[31:24]};
    if (last) begin
      contrib_f = {24'h0, w[7:0]} << {(2'd3 - r), 3'b000};
    end else begin
      case (r)
        2'd0:    contrib_f = {rev[7:0],  rev[31:8]};
        2'd1:    contrib_f = {rev[15:0], rev[31:16]};
        2'd2:    contrib_f = {rev[23:0], rev[31:24]};
        default: contrib_f = rev;
      endcase
    end
  endfunction

`ifdef MIXCOL_SEQ_PIPE_EN
  logic                 drain;
  logic                 p_valid;
  logic [31:0]          p_word;
  logic [1:0]           p_r;
  logic [COLW-1:0]      p_col;
  logic                 p_last;

  assign issue  = (st == S_FEED) && !drain;
  assign a_en   = p_valid;
  assign a_word = p_word;
  assign a_r    = p_r;
  assign a_col  = p_col;
  assign a_last = p_last;
`else
  assign issue  = (st == S_FEED);
  assign a_en   = issue;
  assign a_word = mc_word;
  assign a_r    = cnt[1:0];
  assign a_col  = cnt[CW-1:2];
  assign a_last = last_q;
`endif

  assign state_sh = state_q << {cnt, 3'b000};
  assign contrib  = contrib_f(a_word, a_r, a_last);
  // Row 0 starts a fresh column, so the stale accumulator is dropped there.
  assign col_res  = ((a_r == 2'd0) ? 32'h0 : acc) ^ contrib;

  assign in_ready      = (st == S_IDLE);
  assign busy          = (st == S_FEED);
  assign out_valid     = (st == S_DONE);
  assign out_state     = out_q;
  assign mc_byte       = issue ? state_sh[32*NCOL-1 -: 8] : 8'h00;
  assign mc_last_round = issue ? last_q : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      state_q <= '0;
      last_q  <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      out_q   <= '0;
`ifdef MIXCOL_SEQ_PIPE_EN
      drain   <= 1'b0;
      p_valid <= 1'b0;
      p_word  <= '0;
      p_r     <= '0;
      p_col   <= '0;
      p_last  <= 1'b0;
`endif
    end else begin
      case (st)
        S_IDLE: begin
          if (in_valid) begin
            state_q <= in_state;
            last_q  <= in_last;
            cnt     <= '0;
            acc     <= '0;
            st      <= S_FEED;
          end
        end
        S_FEED: begin
`ifdef MIXCOL_SEQ_PIPE_EN
          if (drain) begin
            drain <= 1'b0;
            st    <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            drain <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`else
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            st  <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          if (out_ready) st <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase

`ifdef MIXCOL_SEQ_PIPE_EN
      p_valid <= issue;
      p_word  <= mc_word;
      p_r     <= cnt[1:0];
      p_col   <= cnt[CW-1:2];
      p_last  <= last_q;
`endif

      // a_en is never set in IDLE, so this cannot collide with the accept clear.
      if (a_en) begin
        acc <= col_res;
        if (a_r == 2'd3) begin
          for (int c = 0; c < NCOL; c++) begin
            if (a_col == COLW'(c)) out_q[32*NCOL-1-32*c -: 32] <= col_res;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mixcol_seq.sv
// tb/tb_mixcol_seq.sv - self-checking bench for mixcol_seq

module tb_mixcol_seq;

`ifdef MIXCOL_SEQ_PIPE_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 16;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_last;
  logic [7:0]   mc_byte;
  logic         mc_last_round;
  logic [31:0]  mc_word;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  localparam logic [127:0] V1  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] R1  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] R2  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] VL  = 128'h00112233_44556677_8899aabb_ccddeeff;

  mixcol_seq #(.NCOL(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_state      (in_state),
    .in_last       (in_last),
    .mc_byte       (mc_byte),
    .mc_last_round (mc_last_round),
    .mc_word       (mc_word),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_state     (out_state),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns byte unit stand-in.
  assign mc_word = mc_last_round ? {24'h0, mc_byte}
                                 : {xt(mc_byte), xt(mc_byte) ^ mc_byte, mc_byte, mc_byte};

  function automatic logic [7:0] get_byte(input logic [127:0] s, input int k);
    logic [127:0] t;
    t = s << (8 * k);
    return t[127:120];
  endfunction

  // Reference: textbook MixColumns matrix per column, identity in the last round.
  function automatic logic [127:0] mix(input logic [127:0] s, input logic last);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    if (last) return s;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(s, 4*c);
      a1 = get_byte(s, 4*c+1);
      a2 = get_byte(s, 4*c+2);
      a3 = get_byte(s, 4*c+3);
      r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [127:0] s, input logic l);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("start_in_ready", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_state = s;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; checks issued bytes, latency and result.
  task automatic collect(input logic [127:0] s, input logic l, input logic [127:0] exp);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat < 16) begin
        chk("feed_byte", 128'(mc_byte), 128'(get_byte(s, lat)));
        chk("feed_last_round", 128'(mc_last_round), 128'(l));
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 128'(lat), 128'(LAT));
    chk("out_state", out_state, exp);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs_out_valid_drop", 128'(out_valid), 128'd0);
    chk("hs_in_ready", 128'(in_ready), 128'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rs;
    logic         rl;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_state", out_state, 128'd0);
    chk("rst_mc_byte", 128'(mc_byte), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_mc_last", 128'(mc_last_round), 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    chk("model_v1", mix(V1, 1'b0), R1);
    chk("model_v2", mix(V2, 1'b0), R2);

    start(V1, 1'b0); collect(V1, 1'b0, R1); handshake();
    chk("idle_mc_byte", 128'(mc_byte), 128'd0);
    start(V2, 1'b0); collect(V2, 1'b0, R2); handshake();
    start(VL, 1'b1); collect(VL, 1'b1, VL); handshake();

    // Backpressure with a new request already waiting.
    start(V2, 1'b0); collect(V2, 1'b0, R2);
    in_valid = 1'b1;
    in_state = V1;
    in_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_out_state", out_state, R2);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_busy", 128'(busy), 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", 128'(out_valid), 128'd0);
    chk("bp_release_idle", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    chk("bp_next_accept", 128'(busy), 128'd1);
    in_valid = 1'b0;
    collect(V1, 1'b0, R1); handshake();

    // Reset while feeding byte 7.
    start(V2, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 128'(out_valid), 128'd0);
    end
    chk("abort_byte7", 128'(mc_byte), 128'(get_byte(V2, 7)));
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_out_state", out_state, 128'd0);
    chk("abort_mc_byte", 128'(mc_byte), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_after_valid", 128'(out_valid), 128'd0);
    start(V1, 1'b0); collect(V1, 1'b0, R1); handshake();

    // Random states against the reference model.
    for (int i = 0; i < 8; i++) begin
      rs = {$urandom, $urandom, $urandom, $urandom};
      rl = ($urandom_range(0, 3) == 0);
      start(rs, rl); collect(rs, rl, mix(rs, rl)); handshake();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
